fan_off_timer_ctrl: RTL and testbench
=====================================

Name: fan_off_timer_ctrl

Overview:
Sequencer for the fan off-timer. It cycles the preset mode from button pulses and loads the preset into an internal BCD HH:MM down-counter. The counter is gated by an upstream minute strobe. On expiry the block issues a fan shut-off request and drives a self-clearing alarm. It sits between the debounced button counters and minute clock divider on one side, and the FND display and fan PWM on the other.

Parameters:
PRESET1, 1, hours loaded in mode 1 (BCD digit, legal 1-9)
PRESET2, 3, hours loaded in mode 2 (legal 1-9)
PRESET3, 5, hours loaded in mode 3 (legal 1-9)
ALARM_TICKS, 10, tick pulses the alarm stays on before auto-clear (legal 1-255)

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous, active-high reset
mode_btn  in  1  single-cycle debounced pulse: advance mode
cancel_btn  in  1  single-cycle debounced pulse: abort timer / clear alarm
tick  in  1  single-cycle minute strobe (sub-rate in sim)
mode  out  2  current preset 0=off, 1..3
timer_active  out  1  high in LOAD and RUN
bcd_time  out  16  {h10,h1,m10,m1} remaining time, BCD
fan_off_req  out  1  single-cycle pulse at expiry
alarm  out  1  alarm indicator

Behaviour:
- Reset (async, any state): state=IDLE, mode=0, bcd_time=0, timer_active=0, fan_off_req=0, alarm=0, alarm counter=0. All outputs are registered.
- States: IDLE, LOAD, RUN, EXPIRE, ALARM.
- IDLE: bcd_time holds 0.
  - mode_btn: mode becomes 1 and the next state is LOAD.
  - cancel_btn and tick are ignored.
- LOAD (exactly 1 cycle): bcd_time <= {4'd0, PRESETmode, 4'd0, 4'd0}, then RUN. A tick arriving in LOAD is dropped. Buttons arriving in LOAD are dropped.
- RUN, priority per cycle is cancel_btn > mode_btn > tick:
  - cancel_btn: go to IDLE with mode=0 and bcd_time=0. No fan_off_req, no alarm.
  - mode_btn: mode=mode+1. If the old mode was 3, mode wraps to 0 and the block returns to IDLE silently (bcd_time=0). Otherwise go to LOAD, which restarts with the new preset.
  - tick: decrement by one minute.
    - If m1>0: m1-1.
    - Otherwise m1=9. Then if m10>0: m10-1.
    - Otherwise m10=5. Then if h1>0: h1-1.
    - Otherwise h1=9 and h10-1.
    - If the pre-decrement value was 00:01, the result is 00:00 and the next state is EXPIRE.
  - RUN never decrements from 0000. No wrap below zero.
  - Every digit stays valid BCD at all times: m10 in 0-5, the others in 0-9.
- EXPIRE (1 cycle): fan_off_req=1 for this cycle only; mode=0; bcd_time stays 0; timer_active=0; then ALARM.
- ALARM: alarm=1.
  - Each tick increments the alarm counter.
  - When the count reaches ALARM_TICKS, alarm goes to 0 in the same edge and the block enters IDLE.
  - Either mode_btn or cancel_btn clears alarm and goes to IDLE. The pulse is consumed and mode is NOT advanced.
  - The alarm counter clears on exit.
- Latency:
  - mode_btn sampled at edge N (from IDLE): LOAD during cycle N+1, preset visible on bcd_time and timer_active=1 from edge N+1/N+2 per the registered outputs above. Preset is valid no later than 2 cycles after the pulse.
  - Expiring tick at edge N: fan_off_req high in cycle N+1; alarm high from N+2.
- Reset mid-RUN or mid-ALARM aborts immediately with no fan_off_req pulse.

Test Plan:
- Reset, then 1 mode_btn -> mode=1, bcd_time=16'h0100 within 2 cycles, timer_active=1. One tick -> 16'h0059. Next tick -> 16'h0058.
- Load mode 1, apply 60 ticks -> 0059 ... 0001, 0000. fan_off_req pulses exactly 1 cycle. alarm=1 from the next cycle. mode=0, timer_active=0.
- In ALARM with ALARM_TICKS=3: 3 ticks -> alarm drops on the 3rd, state IDLE. Repeat with cancel_btn after 1 tick -> alarm drops next cycle, mode stays 0.
- In RUN: press mode_btn 3 times -> bcd_time 0100 -> 0300 -> 0500. A 4th press -> mode=0, bcd_time=0000, no fan_off_req, no alarm.
- Same-cycle events in RUN at 0300: tick+mode_btn -> 0500 (tick ignored). cancel_btn+mode_btn -> IDLE, 0000, mode=0.
- Borrow chain: PRESET3=9 (hence 0900) after 1 tick -> 0859. Assert reset_p mid-count at 0745 -> all outputs 0 asynchronously, no fan_off_req.

Source files
------------

// File: rtl/fan_off_timer_ctrl_if.sv
// Button/tick inputs and timer status outputs of the fan off-timer sequencer.
// The master side is the upstream logic (buttons and minute strobe); the slave side is the sequencer.
interface fan_off_timer_ctrl_if;
  logic        mode_btn;
  logic        cancel_btn;
  logic        tick;
  logic [1:0]  mode;
  logic        timer_active;
  logic [15:0] bcd_time;
  logic        fan_off_req;
  logic        alarm;

  modport master (
    output mode_btn, cancel_btn, tick,
    input  mode, timer_active, bcd_time, fan_off_req, alarm
  );

  modport slave (
    input  mode_btn, cancel_btn, tick,
    output mode, timer_active, bcd_time, fan_off_req, alarm
  );
endinterface

// File: rtl/fan_off_timer_ctrl.sv
// Fan off-timer sequencer: cycles preset mode, counts a BCD HH:MM value down on minute
// ticks, pulses a fan shut-off request on expiry and holds a self-clearing alarm.
module fan_off_timer_ctrl #(
  parameter int unsigned PRESET1     = 1,
  parameter int unsigned PRESET2     = 3,
  parameter int unsigned PRESET3     = 5,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic                        clk,
  input  logic                        reset_p,
  fan_off_timer_ctrl_if.slave         bus_io
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_EXPIRE = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] bcd_q, bcd_d;
  logic [7:0]  alarm_cnt_q, alarm_cnt_d;
  logic        active_q, active_d;
  logic        fan_off_q, fan_off_d;
  logic        alarm_q, alarm_d;
  logic [3:0]  preset_sel;

  // One-minute decrement with per-digit borrow; m10 wraps to 5, the other digits to 9.
  function automatic logic [15:0] dec_minute(input logic [15:0] t);
    logic [3:0] h10, h1, m10, m1;
    h10 = t[15:12];
    h1  = t[11:8];
    m10 = t[7:4];
    m1  = t[3:0];
    if (m1 != 4'd0) begin
      m1 = m1 - 4'd1;
    end else begin
      m1 = 4'd9;
      if (m10 != 4'd0) begin
        m10 = m10 - 4'd1;
      end else begin
        m10 = 4'd5;
        if (h1 != 4'd0) begin
          h1 = h1 - 4'd1;
        end else begin
          h1  = 4'd9;
          h10 = h10 - 4'd1;
        end
      end
    end
    return {h10, h1, m10, m1};
  endfunction

  always_comb begin
    case (mode_q)
      2'd1:    preset_sel = 4'(PRESET1);
      2'd2:    preset_sel = 4'(PRESET2);
      2'd3:    preset_sel = 4'(PRESET3);
      default: preset_sel = 4'd0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    bcd_d       = bcd_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_d     = alarm_q;
    fan_off_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bcd_d   = 16'h0000;
        alarm_d = 1'b0;
        if (bus_io.mode_btn) begin
          mode_d  = 2'd1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        bcd_d   = {4'd0, preset_sel, 8'h00};
        state_d = S_RUN;
      end

      S_RUN: begin
        if (bus_io.cancel_btn) begin
          mode_d  = 2'd0;
          bcd_d   = 16'h0000;
          state_d = S_IDLE;
        end else if (bus_io.mode_btn) begin
          if (mode_q == 2'd3) begin
            mode_d  = 2'd0;
            bcd_d   = 16'h0000;
            state_d = S_IDLE;
          end else begin
            mode_d  = mode_q + 2'd1;
            state_d = S_LOAD;
          end
        end else if (bus_io.tick && (bcd_q != 16'h0000)) begin
          bcd_d = dec_minute(bcd_q);
          if (bcd_q == 16'h0001) begin
            mode_d    = 2'd0;
            fan_off_d = 1'b1;
            state_d   = S_EXPIRE;
          end
        end
      end

      S_EXPIRE: begin
        bcd_d   = 16'h0000;
        alarm_d = 1'b1;
        state_d = S_ALARM;
      end

      S_ALARM: begin
        if (bus_io.mode_btn || bus_io.cancel_btn) begin
          alarm_d     = 1'b0;
          alarm_cnt_d = 8'd0;
          state_d     = S_IDLE;
        end else if (bus_io.tick) begin
          if (alarm_cnt_q == ALARM_LAST) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = 8'd0;
            state_d     = S_IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        mode_d      = 2'd0;
        bcd_d       = 16'h0000;
        alarm_d     = 1'b0;
        alarm_cnt_d = 8'd0;
        state_d     = S_IDLE;
      end
    endcase

    active_d = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      bcd_q       <= 16'h0000;
      alarm_cnt_q <= 8'd0;
      active_q    <= 1'b0;
      fan_off_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      alarm_cnt_q <= alarm_cnt_d;
      active_q    <= active_d;
      fan_off_q   <= fan_off_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus_io.mode         = mode_q;
  assign bus_io.timer_active = active_q;
  assign bus_io.bcd_time     = bcd_q;
  assign bus_io.fan_off_req  = fan_off_q;
  assign bus_io.alarm        = alarm_q;

endmodule

// File: tb/tb_fan_off_timer_ctrl.sv
// Self-checking bench for fan_off_timer_ctrl: vector table plus run-down, alarm and reset sequences.
module tb_fan_off_timer_ctrl;

  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 3;
  localparam int unsigned P3 = 9;
  localparam int unsigned AT = 3;

  typedef struct packed {
    logic        mb;
    logic        cb;
    logic        tk;
    logic [1:0]  mode;
    logic        act;
    logic [15:0] bcd;
    logic        fan;
    logic        alm;
  } vec_t;

  logic clk;
  logic reset_p;
  int   checks;
  int   failures;
  vec_t exp_q[$];
  vec_t tbl[18];

  fan_off_timer_ctrl_if bus_if();

  fan_off_timer_ctrl #(
    .PRESET1    (P1),
    .PRESET2    (P2),
    .PRESET3    (P3),
    .ALARM_TICKS(AT)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic mb, input logic cb, input logic tk,
                              input logic [1:0] mode, input logic act,
                              input logic [15:0] bcd, input logic fan, input logic alm);
    vec_t v;
    v.mb = mb; v.cb = cb; v.tk = tk;
    v.mode = mode; v.act = act; v.bcd = bcd; v.fan = fan; v.alm = alm;
    return v;
  endfunction

  // Remaining time in whole minutes rendered as {h10,h1,m10,m1}.
  function automatic logic [15:0] to_bcd(input int minutes);
    int h;
    int m;
    h = minutes / 60;
    m = minutes % 60;
    return {4'd0, 4'(h), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic compare_out(input string tag);
    vec_t e;
    e = exp_q.pop_front();
    check({tag, ".mode"}, 16'(bus_if.mode), 16'(e.mode));
    check({tag, ".active"}, 16'(bus_if.timer_active), 16'(e.act));
    check({tag, ".bcd"}, bus_if.bcd_time, e.bcd);
    check({tag, ".fan_off"}, 16'(bus_if.fan_off_req), 16'(e.fan));
    check({tag, ".alarm"}, 16'(bus_if.alarm), 16'(e.alm));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus_if.mode_btn   = v.mb;
    bus_if.cancel_btn = v.cb;
    bus_if.tick       = v.tk;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    bus_if.mode_btn   = 1'b0;
    bus_if.cancel_btn = 1'b0;
    bus_if.tick       = 1'b0;
    compare_out(tag);
  endtask

  // From IDLE: load mode 1 (60 minutes), count it down to expiry and enter ALARM.
  task automatic run_to_alarm(input string tag);
    apply(mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0), {tag, ".load"});
    apply(mk(0, 0, 0, 2'd1, 1, 16'h0100, 0, 0), {tag, ".preset"});
    for (int k = 1; k < 60; k++)
      apply(mk(0, 0, 1, 2'd1, 1, to_bcd(60 - k), 0, 0), $sformatf("%s.tick%0d", tag, k));
    apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 1, 0), {tag, ".expire"});
    apply(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 1), {tag, ".alarm_on"});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus_if.mode_btn   = 1'b0;
    bus_if.cancel_btn = 1'b0;
    bus_if.tick       = 1'b0;

    tbl[0]  = mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 2'd1, 1, 16'h0100, 0, 0);
    tbl[2]  = mk(0, 0, 1, 2'd1, 1, 16'h0059, 0, 0);
    tbl[3]  = mk(0, 0, 1, 2'd1, 1, 16'h0058, 0, 0);
    tbl[4]  = mk(1, 0, 0, 2'd2, 1, 16'h0058, 0, 0);
    tbl[5]  = mk(0, 0, 1, 2'd2, 1, 16'h0300, 0, 0);
    tbl[6]  = mk(1, 0, 1, 2'd3, 1, 16'h0300, 0, 0);
    tbl[7]  = mk(0, 0, 0, 2'd3, 1, 16'h0900, 0, 0);
    tbl[8]  = mk(0, 0, 1, 2'd3, 1, 16'h0859, 0, 0);
    tbl[9]  = mk(1, 0, 0, 2'd0, 0, 16'h0000, 0, 0);
    tbl[10] = mk(0, 1, 1, 2'd0, 0, 16'h0000, 0, 0);
    tbl[11] = mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0);
    tbl[12] = mk(0, 0, 0, 2'd1, 1, 16'h0100, 0, 0);
    tbl[13] = mk(1, 1, 0, 2'd0, 0, 16'h0000, 0, 0);
    tbl[14] = mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0);
    tbl[15] = mk(0, 1, 0, 2'd1, 1, 16'h0100, 0, 0);
    tbl[16] = mk(0, 1, 0, 2'd0, 0, 16'h0000, 0, 0);
    tbl[17] = mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 0);

    reset_p = 1'b1;
    #12;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 0));
    compare_out("reset");
    @(negedge clk);
    reset_p = 1'b0;

    for (int i = 0; i < 18; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Alarm auto-clears on the AT-th tick.
    run_to_alarm("run1");
    for (int k = 1; k < int'(AT); k++)
      apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 1), $sformatf("run1.atick%0d", k));
    apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 0), "run1.autoclear");
    apply(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 0), "run1.idle");

    // Cancel after one alarm tick.
    run_to_alarm("run2");
    apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 1), "run2.atick");
    apply(mk(0, 1, 0, 2'd0, 0, 16'h0000, 0, 0), "run2.cancel");
    apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 0), "run2.idle");

    // A fresh alarm must again last the full AT ticks.
    run_to_alarm("run3");
    for (int k = 1; k < int'(AT); k++)
      apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 1), $sformatf("run3.atick%0d", k));
    apply(mk(0, 0, 1, 2'd0, 0, 16'h0000, 0, 0), "run3.autoclear");

    // mode_btn clears the alarm without advancing mode.
    run_to_alarm("run4");
    apply(mk(1, 0, 0, 2'd0, 0, 16'h0000, 0, 0), "run4.mbclear");
    apply(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 0), "run4.idle");

    // Borrow chain from the largest preset down to 07:45, then async reset.
    apply(mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0), "chain.m1");
    apply(mk(0, 0, 0, 2'd1, 1, 16'h0100, 0, 0), "chain.p1");
    apply(mk(1, 0, 0, 2'd2, 1, 16'h0100, 0, 0), "chain.m2");
    apply(mk(0, 0, 0, 2'd2, 1, 16'h0300, 0, 0), "chain.p2");
    apply(mk(1, 0, 0, 2'd3, 1, 16'h0300, 0, 0), "chain.m3");
    apply(mk(0, 0, 0, 2'd3, 1, 16'h0900, 0, 0), "chain.p3");
    for (int k = 1; k <= 75; k++)
      apply(mk(0, 0, 1, 2'd3, 1, to_bcd(540 - k), 0, 0), $sformatf("chain.tick%0d", k));

    @(negedge clk);
    bus_if.tick = 1'b1;
    #2 reset_p = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 0));
    compare_out("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0000, 0, 0));
    compare_out("reset_hold");
    @(negedge clk);
    reset_p     = 1'b0;
    bus_if.tick = 1'b0;
    apply(mk(1, 0, 0, 2'd1, 1, 16'h0000, 0, 0), "post_reset.load");
    apply(mk(0, 0, 0, 2'd1, 1, 16'h0100, 0, 0), "post_reset.preset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
